div_seq: RTL and testbench

- Iterative restoring divider and its sequencer, serving the EX stage for DIV/DIVU.
- EX holds `start_i` with its operands and holds its stall request until `ready_o`. It then captures `result_o` into HI/LO and drops `start_i`.
- `annul_i` comes from the pipeline control block. It aborts a division in flight when the pipeline is flushed by an exception or ERET.
- The operation is held in a single state machine: one quotient bit per cycle, with sign fix-up on completion.

---
 rtl/div_seq_pkg.sv | 30 +++
 rtl/div_seq.sv | 154 +++++++++++++++
 tb/tb_div_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module  : div_seq_pkg
// Purpose : Shared encodings and bus widths for the iterative divider.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module  : div_seq
// Purpose : Restoring divider for DIV/DIVU, one quotient bit per clock.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = RegBus
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 neg_dvd_q, neg_dvd_d;
    logic                 neg_dvs_q, neg_dvs_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [2*WIDTH:0]     shifted;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   step;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     rem;
    logic                 op1_neg;
    logic                 op2_neg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DivFree;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= ZeroWord;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DivResultNotReady;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            neg_dvd_q <= neg_dvd_d;
            neg_dvs_q <= neg_dvs_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    // Trial value is {work, 0}, WIDTH+1 bits of remainder on top. Its MSB is
    // provably clear whenever the restored value is kept, so storage is 2*WIDTH.
    always_comb begin
        shifted = {work_q, 1'b0};
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_q};
        if (diff[WIDTH]) begin
            step = shifted[2*WIDTH-1:0];
        end else begin
            step = {diff[WIDTH-1:0], shifted[WIDTH-1:1], 1'b1};
        end
        quot    = step[WIDTH-1:0];
        rem     = step[2*WIDTH-1:WIDTH];
        op1_neg = signed_div_i & opdata1_i[WIDTH-1];
        op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        neg_dvd_d = neg_dvd_q;
        neg_dvs_d = neg_dvs_q;
        result_d  = result_q;
        ready_d   = ready_q;

        if (state_q != DivFree && annul_i) begin
            state_d  = DivFree;
            result_d = '0;
            ready_d  = DivResultNotReady;
        end else begin
            case (state_q)
                DivFree: begin
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                    if (start_i == DivStart && !annul_i) begin
                        neg_dvd_d = op1_neg;
                        neg_dvs_d = op2_neg;
                        divisor_d = op2_neg ? negate(opdata2_i) : opdata2_i;
                        if (opdata2_i == ZeroWord) begin
                            state_d = DivByZero;
                        end else begin
                            cnt_d   = '0;
                            work_d  = {ZeroWord, (op1_neg ? negate(opdata1_i) : opdata1_i)};
                            state_d = DivOn;
                        end
                    end
                end
                DivByZero: begin
                    result_d = {ZeroWord, ZeroWord};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
                DivOn: begin
                    work_d = step;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Remainder follows the dividend's sign.
                        result_d = {(neg_dvd_q ? negate(rem) : rem),
                                    ((neg_dvd_q ^ neg_dvs_q) ? negate(quot) : quot)};
                        ready_d  = DivResultReady;
                        state_d  = DivEnd;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        result_d = '0;
                        ready_d  = DivResultNotReady;
                        state_d  = DivFree;
                    end
                end
                default: begin
                    state_d = DivFree;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q == DivByZero) || (state_q == DivOn);

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module  : tb_div_seq
// Purpose : Directed vector bench for div_seq, plus abort/hold sequences.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic        sdiv;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[11];

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives one division; optionally scrambles the operand inputs at RUN cycle chg_at.
    task automatic run_div(input vec_t v, input int chg_at);
        int edges;
        int busy_n;
        @(negedge clk);
        signed_div = v.sdiv;
        op1        = v.a;
        op2        = v.b;
        start      = 1'b1;
        edges      = 0;
        busy_n     = 0;
        do begin
            @(negedge clk);
            edges++;
            if (busy) busy_n++;
            if (chg_at != 0 && edges == chg_at) begin
                op1 = ~v.a;
                op2 = v.b + 32'd5;
            end
        end while (!ready && edges < 100);
        chk("latency", 64'(edges), 64'(v.lat));
        chk("result", result, v.exp);
        chk("busy_cycles", 64'(busy_n), 64'(v.lat - 1));
        @(negedge clk);
        chk("hold_ready", {63'd0, ready}, 64'd1);
        chk("hold_result", result, v.exp);
        start = 1'b0;
        @(negedge clk);
        chk("clear_ready", {63'd0, ready}, 64'd0);
        chk("clear_result", result, 64'd0);
    endtask

    initial begin
        logic seen;

        vt[0]  = '{1'b0, 32'h0000_0064, 32'h0000_0007, 64'h00000002_0000000E, 33};
        vt[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFFFFFF_FFFFFFFD, 33};
        vt[2]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33};
        vt[3]  = '{1'b0, 32'h1234_5678, 32'h0000_0000, 64'h00000000_00000000, 2};
        vt[4]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33};
        vt[5]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 64'h80000000_00000000, 33};
        vt[6]  = '{1'b0, 32'h0000_0032, 32'h0000_0005, 64'h00000000_0000000A, 33};
        vt[7]  = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFFFFFE_0000000E, 33};
        vt[8]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h00000000_FFFFFFFF, 33};
        vt[9]  = '{1'b1, 32'h0000_0000, 32'hFFFF_FFFB, 64'h00000000_00000000, 33};
        vt[10] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 64'h00000000_00000000, 2};

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_div(vt[i], 0);
        end

        // Operands disturbed during RUN must not affect the latched division.
        run_div(vt[0], 3);

        // Annul at RUN cycle 10.
        @(negedge clk);
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        chk("annul_busy", {63'd0, busy}, 64'd0);
        chk("annul_ready", {63'd0, ready}, 64'd0);
        chk("annul_result", result, 64'd0);
        annul = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        run_div(vt[6], 0);

        // Synchronous reset at RUN cycle 20.
        @(negedge clk);
        signed_div = 1'b1; op1 = 32'hFFFF_FFF9; op2 = 32'd2; start = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_result", result, 64'd0);
        rst = 1'b0; start = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
        end
        chk("rst_no_ready", {63'd0, seen}, 64'd0);
        run_div(vt[6], 0);

        // Start with annul held in IDLE: no state change.
        @(negedge clk);
        op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_annul_busy", {63'd0, busy}, 64'd0);
            chk("idle_annul_ready", {63'd0, ready}, 64'd0);
        end
        start = 1'b0; annul = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
